cla_result_capture: RTL and testbench
=====================================

# cla_result_capture

Registered result stage directly downstream of the carry-lookahead adder. It captures the adder's sum, carry-out and overflow under a valid/ready handshake and holds them in a 2-entry skid buffer, so a stalled consumer never drops a result. It also keeps a sticky overflow flag and an optional saturating overflow-event counter for the lab's critical-path and stress tests.

## Interface
Parameters:
- `Ancho`, 8, operand width of the upstream adder; the sum path is `Ancho+1` bits.
- `CntW`, 8, width of the overflow-event counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents a result.
- `in_ready`  out  1  stage can accept a result this cycle.
- `in_sum`  in  Ancho+1  adder sum S.
- `in_cout`  in  1  adder carry-out.
- `in_ovf`  in  1  adder signed overflow.
- `out_valid`  out  1  registered result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  Ancho+1  registered sum.
- `out_cout`  out  1  registered carry-out.
- `out_ovf`  out  1  registered overflow.
- `ovf_sticky`  out  1  set once any accepted result had `in_ovf=1`.
- `ovf_clr`  in  1  synchronous clear of `ovf_sticky` and `ovf_count`.
- `ovf_count`  out  CntW  count of accepted results with `in_ovf=1`; saturating.

## Operation
- Accept (in_fire) = `in_valid & in_ready`. Deliver (out_fire) = `out_valid & out_ready`.
- Storage: main register (drives `out_*`) and skid register, each holding {sum, cout, ovf}.
- FSM states: EMPTY, ONE (main full), TWO (main and skid full).
  - EMPTY: in_fire -> ONE, load main.
  - ONE: in_fire & !out_fire -> TWO, load skid. in_fire & out_fire -> ONE, load main with new data. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - TWO: out_fire -> ONE, main <= skid. Otherwise hold. No accept is possible in TWO.
- `in_ready = (state != TWO)`. It depends only on the state flop, with no combinational path from `out_ready`.
- `out_valid = (state != EMPTY)`.
- Strict FIFO order. Results are never duplicated or dropped. Data in the main register is stable while `out_valid & !out_ready`.
- No arithmetic on data. Fields are stored bit-exact; `in_sum` keeps the full `Ancho+1` bits.
- Sticky flag:
  - Set on in_fire & `in_ovf`.
  - Cleared on `ovf_clr`.
  - If set and clear occur in the same cycle, set wins (flag = 1).
- Counter:
  - Increments by 1 on in_fire & `in_ovf`.
  - Holds at all-ones (`2^CntW-1`) once reached.
  - `ovf_clr` -> 0. If clear and an event occur in the same cycle, the counter becomes 1.
- `in_valid` while `in_ready=0` is ignored. Upstream must hold its data until accepted.

## Timing
- Latency: a result accepted at edge N appears on `out_*` with `out_valid=1` after edge N (cycle N+1) when the stage was EMPTY.
- Throughput: 1 result/cycle sustained while `out_ready=1`.
- Stall: with `out_ready=0`, two results are accepted, then `in_ready` drops in the cycle after the second accept.
- Release: `in_ready` returns 1 the cycle after the first out_fire in TWO.
- Reset (asynchronous, while `rst_n=0`):
  - state = EMPTY.
  - `out_valid=0`, `in_ready=1`.
  - `out_sum=0`, `out_cout=0`, `out_ovf=0`, skid register = 0.
  - `ovf_sticky=0`, `ovf_count=0`.
- Reset mid-operation discards all buffered entries immediately. The first edge after deassertion behaves as EMPTY.

## Configuration
- Macro `CLA_RESULT_OVF_CNT_EN`.
- Defined: the `ovf_count` counter is implemented as specified.
- Undefined: no counter flops. `ovf_count` is tied to 0 and the port stays present. `ovf_sticky` and all datapath behaviour are unchanged.

## Test plan
All scenarios use `Ancho=8` and `CntW=8`.
- Reset: assert `rst_n=0` mid-stream with two entries buffered. Required: `out_valid=0`, `in_ready=1`, `ovf_count=0` immediately. After release, the next accept of `in_sum=9'h07F` appears alone on `out_*`.
- Passthrough: `out_ready=1`, feed sums 9'h07F, 9'h100, 9'h0FF back-to-back. Required: each appears one cycle later, in order, with no bubbles.
- Skid: `out_ready=0`, offer 9'h011, 9'h022, 9'h033. Required: first two accepted, then `in_ready=0`. Raising `out_ready` delivers 9'h011, then 9'h022, then 9'h033 is accepted.
- Overflow: accept `in_sum=9'h080` with `in_ovf=1` (signed 127+1). Required: `ovf_sticky=1` and `ovf_count=1` next cycle. `ovf_clr` together with another overflow accept leaves `ovf_sticky=1` and `ovf_count=1`.
- Saturation: 300 accepted results with `in_ovf=1`. Required: `ovf_count=8'hFF` and held. Without `CLA_RESULT_OVF_CNT_EN`, `ovf_count=0` throughout while `ovf_sticky=1`.
- Random: random `in_valid`/`out_ready` for 10k cycles against a scoreboard. Required: order preserved, zero loss, `in_ready=0` only in TWO.

Source files
------------

// File: rtl/cla_result_capture.sv
// Registered result stage behind the carry-lookahead adder: 2-entry skid buffer plus overflow tracking.
// Optional saturating overflow-event counter enabled by defining CLA_RESULT_OVF_CNT_EN.
module cla_result_capture #(
    parameter int Ancho = 8,
    parameter int CntW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Ancho:0]   in_sum,
    input  logic             in_cout,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Ancho:0]   out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    output logic [CntW-1:0]  ovf_count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam int EntW = Ancho + 3;

    state_t          state;
    state_t          nextState;
    logic [EntW-1:0] mainReg;
    logic [EntW-1:0] skidReg;
    logic            loadMain;
    logic            loadSkid;
    logic            mainFromSkid;
    logic            inFire;
    logic            outFire;
    logic            ovfEvent;

    // Ready and valid come straight from the state flop, so no combinational ready path exists.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign inFire    = in_valid & in_ready;
    assign outFire   = out_valid & out_ready;
    assign ovfEvent  = inFire & in_ovf;

    assign out_sum  = mainReg[EntW-1:2];
    assign out_cout = mainReg[1];
    assign out_ovf  = mainReg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        loadMain     = 1'b0;
        loadSkid     = 1'b0;
        mainFromSkid = 1'b0;
        case (state)
            EMPTY: begin
                if (inFire) begin
                    nextState = ONE;
                    loadMain  = 1'b1;
                end
            end
            ONE: begin
                if (inFire && !outFire) begin
                    nextState = TWO;
                    loadSkid  = 1'b1;
                end else if (inFire && outFire) begin
                    loadMain = 1'b1;
                end else if (outFire) begin
                    nextState = EMPTY;
                end
            end
            TWO: begin
                if (outFire) begin
                    nextState    = ONE;
                    mainFromSkid = 1'b1;
                end
            end
            default: nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainReg <= '0;
            skidReg <= '0;
        end else begin
            if (loadMain) begin
                mainReg <= {in_sum, in_cout, in_ovf};
            end else if (mainFromSkid) begin
                mainReg <= skidReg;
            end
            if (loadSkid) begin
                skidReg <= {in_sum, in_cout, in_ovf};
            end
        end
    end

    // A new overflow event takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (ovfEvent) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

`ifdef CLA_RESULT_OVF_CNT_EN
    logic [CntW-1:0] ovfCountReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfCountReg <= '0;
        end else if (ovfEvent) begin
            if (ovf_clr) begin
                ovfCountReg <= CntW'(1);
            end else if (ovfCountReg != {CntW{1'b1}}) begin
                ovfCountReg <= ovfCountReg + CntW'(1);
            end
        end else if (ovf_clr) begin
            ovfCountReg <= '0;
        end
    end

    assign ovf_count = ovfCountReg;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_cla_result_capture.sv
// Self-checking bench for cla_result_capture: vector table, scoreboard queue and corner-case sequences.
// Expected ovf_count follows CLA_RESULT_OVF_CNT_EN.
module tb_cla_result_capture;

`ifdef CLA_RESULT_OVF_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    typedef struct {
        logic       v;
        logic [8:0] sum;
        logic       ordy;
        logic       expRdy;
        logic       expOv;
        logic [8:0] expSum;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_sum;
    logic       in_cout;
    logic       in_ovf;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_sum;
    logic       out_cout;
    logic       out_ovf;
    logic       ovf_sticky;
    logic       ovf_clr;
    logic [7:0] ovf_count;

    res_t q[$];
    logic mSticky;
    int   mCount;
    int   checks;
    int   errors;
    logic lastFire;
    vec_t vecs[13];

    cla_result_capture #(.Ancho(8), .CntW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
        .ovf_count  (ovf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkBit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the reference model of the state before the coming edge.
    task automatic checkOutput();
        checkBit("in_ready", 32'(in_ready), 32'(q.size() < 2));
        checkBit("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            checkBit("out_sum", 32'(out_sum), 32'(q[0].sum));
            checkBit("out_cout", 32'(out_cout), 32'(q[0].cout));
            checkBit("out_ovf", 32'(out_ovf), 32'(q[0].ovf));
        end
        checkBit("ovf_sticky", 32'(ovf_sticky), 32'(mSticky));
        checkBit("ovf_count", 32'(ovf_count), 32'(mCount));
    endtask

    task automatic applyStimulus(input logic v, input logic [8:0] sum, input logic cout,
                                 input logic ovf, input logic ordy, input logic clr);
        in_valid  = v;
        in_sum    = sum;
        in_cout   = cout;
        in_ovf    = ovf;
        out_ready = ordy;
        ovf_clr   = clr;
        @(negedge clk);
        checkOutput();
    endtask

    // Advance the model across the rising edge using the inputs currently driven.
    task automatic endCycle();
        logic inFire;
        logic outFire;
        @(posedge clk);
        inFire  = in_valid && (q.size() < 2);
        outFire = (q.size() != 0) && out_ready;
        if (outFire) void'(q.pop_front());
        if (inFire) q.push_back('{sum: in_sum, cout: in_cout, ovf: in_ovf});
        if (inFire && in_ovf) mSticky = 1'b1;
        else if (ovf_clr) mSticky = 1'b0;
        if (CntEn) begin
            if (inFire && in_ovf) mCount = ovf_clr ? 1 : ((mCount < 255) ? mCount + 1 : 255);
            else if (ovf_clr) mCount = 0;
        end
        lastFire = inFire;
        #1;
    endtask

    task automatic step(input logic v, input logic [8:0] sum, input logic cout,
                        input logic ovf, input logic ordy, input logic clr);
        applyStimulus(v, sum, cout, ovf, ordy, clr);
        endCycle();
    endtask

    task automatic modelReset();
        q.delete();
        mSticky = 1'b0;
        mCount  = 0;
    endtask

    initial begin
        logic       pend;
        logic       pv;
        logic [8:0] psum;
        logic       pcout;
        logic       povf;
        checks   = 0;
        errors   = 0;
        lastFire = 1'b0;
        modelReset();

        vecs[0]  = '{1'b1, 9'h07F, 1'b1, 1'b1, 1'b0, 9'h000};
        vecs[1]  = '{1'b1, 9'h100, 1'b1, 1'b1, 1'b1, 9'h07F};
        vecs[2]  = '{1'b1, 9'h0FF, 1'b1, 1'b1, 1'b1, 9'h100};
        vecs[3]  = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 9'h0FF};
        vecs[4]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 9'h000};
        vecs[5]  = '{1'b1, 9'h011, 1'b0, 1'b1, 1'b0, 9'h000};
        vecs[6]  = '{1'b1, 9'h022, 1'b0, 1'b1, 1'b1, 9'h011};
        vecs[7]  = '{1'b1, 9'h033, 1'b0, 1'b0, 1'b1, 9'h011};
        vecs[8]  = '{1'b1, 9'h033, 1'b1, 1'b0, 1'b1, 9'h011};
        vecs[9]  = '{1'b1, 9'h033, 1'b0, 1'b1, 1'b1, 9'h022};
        vecs[10] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 9'h022};
        vecs[11] = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b1, 9'h033};
        vecs[12] = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 9'h000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_cout   = 1'b0;
        in_ovf    = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk);
        checkBit("rst_out_valid", 32'(out_valid), 32'd0);
        checkBit("rst_in_ready", 32'(in_ready), 32'd1);
        checkBit("rst_out_sum", 32'(out_sum), 32'd0);
        checkBit("rst_sticky", 32'(ovf_sticky), 32'd0);
        checkBit("rst_count", 32'(ovf_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] vector table: passthrough and skid");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].v, vecs[i].sum, 1'b0, 1'b0, vecs[i].ordy, 1'b0);
            checkBit($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expRdy));
            checkBit($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].expOv));
            if (vecs[i].expOv) begin
                checkBit($sformatf("vec%0d_out_sum", i), 32'(out_sum), 32'(vecs[i].expSum));
            end
            endCycle();
        end

        $display("[TB] overflow sticky and counter");
        step(1'b1, 9'h080, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkBit("ovf_sticky_set", 32'(ovf_sticky), 32'd1);
        checkBit("ovf_count_one", 32'(ovf_count), CntEn ? 32'd1 : 32'd0);
        checkBit("ovf_data", 32'({out_sum, out_ovf}), 32'({9'h080, 1'b1}));
        endCycle();
        step(1'b1, 9'h081, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkBit("clr_vs_set_sticky", 32'(ovf_sticky), 32'd1);
        checkBit("clr_vs_set_count", 32'(ovf_count), CntEn ? 32'd1 : 32'd0);
        endCycle();
        step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkBit("clr_only_sticky", 32'(ovf_sticky), 32'd0);
        checkBit("clr_only_count", 32'(ovf_count), 32'd0);
        endCycle();

        $display("[TB] counter saturation");
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 9'($urandom_range(0, 511)), 1'b0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 9'h155, 1'b1, 1'b1, 1'b1, 1'b0);
        checkBit("sat_count", 32'(ovf_count), CntEn ? 32'd255 : 32'd0);
        checkBit("sat_sticky", 32'(ovf_sticky), 32'd1);
        endCycle();
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkBit("sat_hold", 32'(ovf_count), CntEn ? 32'd255 : 32'd0);
        endCycle();

        $display("[TB] random handshake");
        pend = 1'b0;
        pv = 1'b0; psum = '0; pcout = 1'b0; povf = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!pend) begin
                pv    = ($urandom_range(0, 3) != 0);
                psum  = 9'($urandom_range(0, 511));
                pcout = 1'($urandom_range(0, 1));
                povf  = ($urandom_range(0, 3) == 0);
            end
            step(pv, psum, pcout, povf, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0));
            pend = pv && !lastFire;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset with two entries buffered");
        step(1'b1, 9'h0AA, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 9'h0BB, 1'b1, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkBit("midrst_out_valid", 32'(out_valid), 32'd0);
        checkBit("midrst_in_ready", 32'(in_ready), 32'd1);
        checkBit("midrst_count", 32'(ovf_count), 32'd0);
        checkBit("midrst_sticky", 32'(ovf_sticky), 32'd0);
        modelReset();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 9'h07F, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkBit("post_rst_valid", 32'(out_valid), 32'd1);
        checkBit("post_rst_sum", 32'(out_sum), 32'h07F);
        endCycle();
        applyStimulus(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        checkBit("post_rst_alone", 32'(out_valid), 32'd0);
        endCycle();

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
